// File: rtl/player_input_hub_pkg.sv
// Shared types and helpers for the player input hub: facing direction,
// button bit positions within a player's 5-bit group, and direction priority.
package player_input_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_FIRE  = 4;
    localparam int NUM_BTNS  = 5;

    // Held-direction priority: up > down > left > right.
    function automatic dir_t resolve_dir(input logic [3:0] held);
        if (held[BTN_UP])         return DIR_UP;
        else if (held[BTN_DOWN])  return DIR_DOWN;
        else if (held[BTN_LEFT])  return DIR_LEFT;
        else if (held[BTN_RIGHT]) return DIR_RIGHT;
        return DIR_UP;
    endfunction

endpackage

// File: rtl/player_input_hub_if.sv
// Pin/game-side bundle for player_input_hub; the hub uses the slave modport,
// whatever drives the raw pins and the fire acknowledges uses master.
interface player_input_hub_if
    import player_input_pkg::*;
#(
    parameter int NUM_PLAYERS = 2
);
    logic [NUM_PLAYERS*NUM_BTNS-1:0] i_btn;
    logic                            i_enable;
    logic [NUM_PLAYERS-1:0]          i_fire_ack;
    logic [NUM_PLAYERS*2-1:0]        o_dir;
    logic [NUM_PLAYERS-1:0]          o_move;
    logic [NUM_PLAYERS-1:0]          o_fire_req;
    logic [NUM_PLAYERS*NUM_BTNS-1:0] o_led;

    modport master (
        output i_btn, i_enable, i_fire_ack,
        input  o_dir, o_move, o_fire_req, o_led
    );

    modport slave (
        input  i_btn, i_enable, i_fire_ack,
        output o_dir, o_move, o_fire_req, o_led
    );
endinterface

// File: rtl/player_input_hub_debouncer.sv
// One raw button pin: 2-FF synchroniser, polarity fix, and a stability
// counter that only accepts a level after DEB_CYCLES agreeing cycles.
module input_debouncer #(
    parameter int DEB_CYCLES = 250000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level
);
    localparam int   CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0);

    logic [1:0]    sync_q;
    logic          synced;
    logic [CW-1:0] cnt;

    // Synchroniser resets to the released pin level so reset exit is quiet.
    assign synced = sync_q[1] ^ IDLE_PIN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {2{IDLE_PIN}};
            cnt     <= '0;
            o_level <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_raw};
            if (synced == o_level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                o_level <= synced;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/player_input_hub.sv
// N-player controller front end: debounce, direction resolution, move pulses,
// fire req/ack and LEDs. Define INPUT_REPEAT_EN for held-direction auto-repeat.
module player_input_hub
    import player_input_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int DEB_CYCLES    = 250000,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input logic               clk,
    input logic               rst_n,
    player_input_hub_if.slave bus
);
    logic [NUM_PLAYERS*NUM_BTNS-1:0] deb;

    for (genvar b = 0; b < NUM_PLAYERS*NUM_BTNS; b++) begin : g_deb
        input_debouncer #(
            .DEB_CYCLES (DEB_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (bus.i_btn[b]),
            .o_level (deb[b])
        );
    end

    assign bus.o_led = deb;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [3:0] held, held_prev;
        logic       fire, fire_prev;
        logic       dir_valid, press_edge, fire_edge, rep_pulse;
        logic       move_q, req_q;
        dir_t       resolved, dir_q;

        assign held       = deb[p*NUM_BTNS +: 4];
        assign fire       = deb[p*NUM_BTNS + BTN_FIRE];
        assign dir_valid  = |held;
        assign resolved   = resolve_dir(held);
        assign press_edge = |(held & ~held_prev);
        assign fire_edge  = fire & ~fire_prev;

`ifdef INPUT_REPEAT_EN
        localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int REP_W   = $clog2(REP_MAX) + 1;
        logic [REP_W-1:0] rep_cnt;
        logic             rep_armed, rep_run;

        // Counter only runs while the same resolved direction stays held.
        assign rep_run   = bus.i_enable && dir_valid && !press_edge && (resolved == dir_q);
        assign rep_pulse = rep_run && (rep_cnt == (rep_armed ? REP_W'(REPEAT_PERIOD - 1)
                                                             : REP_W'(REPEAT_DELAY - 1)));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (!rep_run) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (rep_pulse) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
`else
        assign rep_pulse = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                held_prev <= '0;
                fire_prev <= 1'b0;
                dir_q     <= DIR_UP;
                move_q    <= 1'b0;
                req_q     <= 1'b0;
            end else begin
                held_prev <= held;
                fire_prev <= fire;
                if (!bus.i_enable) begin
                    move_q <= 1'b0;
                    req_q  <= 1'b0;
                end else begin
                    move_q <= press_edge | rep_pulse;
                    if (dir_valid)
                        dir_q <= resolved;
                    // A press coinciding with an ack starts a fresh request.
                    if (fire_edge && (!req_q || bus.i_fire_ack[p]))
                        req_q <= 1'b1;
                    else if (bus.i_fire_ack[p])
                        req_q <= 1'b0;
                end
            end
        end

        assign bus.o_dir[p*2 +: 2]  = dir_q;
        assign bus.o_move[p]        = move_q;
        assign bus.o_fire_req[p]    = req_q;
    end
endmodule

// File: tb/tb_player_input_hub.sv
// Directed bench for player_input_hub with DEB_CYCLES=4, two players,
// active-low pins; the repeat pattern is checked when INPUT_REPEAT_EN is set.
module tb_player_input_hub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   mv_cnt [2];
    logic [9:0] led_seen;

    always #5 clk = ~clk;

    player_input_hub_if #(.NUM_PLAYERS(2)) bus ();

    player_input_hub #(
        .NUM_PLAYERS   (2),
        .DEB_CYCLES    (4),
        .ACTIVE_LOW    (1),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) if (bus.o_move[p]) mv_cnt[p]++;
        led_seen |= bus.o_led;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        mv_cnt[0] = 0;
        mv_cnt[1] = 0;
        led_seen  = '0;
    endtask

    task automatic test_reset();
        bus.i_btn = '1; bus.i_enable = 1'b1; bus.i_fire_ack = '0;
        rst_n = 1'b0;
        #23;
        checks++;
        if ({bus.o_dir, bus.o_move, bus.o_fire_req, bus.o_led} !== 26'd0) begin
            failures++;
            $display("FAIL reset_hold: got %h expected 0", {bus.o_dir, bus.o_move, bus.o_fire_req, bus.o_led});
        end
        rst_n = 1'b1;
        clear_counts();
        run(8);
        checks++;
        if ({bus.o_dir, bus.o_fire_req, bus.o_led} !== 24'd0 || mv_cnt[0] + mv_cnt[1] != 0 || led_seen !== '0) begin
            failures++;
            $display("FAIL reset_exit: dir/req/led=%h moves=%0d expected 0", {bus.o_dir, bus.o_fire_req, bus.o_led}, mv_cnt[0] + mv_cnt[1]);
        end
    endtask

    task automatic test_press_latency();
        clear_counts();
        bus.i_btn[1] = 1'b0;
        run(5);
        checks++;
        if (bus.o_led !== 10'd0) begin
            failures++; $display("FAIL led_early: got %h expected 000", bus.o_led);
        end
        run(1);
        checks++;
        if (bus.o_led !== 10'h002 || bus.o_move !== 2'b00) begin
            failures++; $display("FAIL led_at_6: led=%h move=%b expected led=002 move=00", bus.o_led, bus.o_move);
        end
        run(1);
        checks++;
        if (bus.o_move !== 2'b01 || bus.o_dir[1:0] !== 2'd2) begin
            failures++; $display("FAIL move_at_7: move=%b dir=%0d expected move=01 dir=2", bus.o_move, bus.o_dir[1:0]);
        end
        run(1);
        checks++;
        if (bus.o_move !== 2'b00) begin
            failures++; $display("FAIL move_width: move=%b expected 00", bus.o_move);
        end
        checks++;
        if (bus.o_dir[3:2] !== 2'd0 || mv_cnt[1] != 0 || bus.o_led[9:5] !== 5'd0) begin
            failures++; $display("FAIL p1_isolated: dir=%0d moves=%0d led=%h expected 0 0 0", bus.o_dir[3:2], mv_cnt[1], bus.o_led[9:5]);
        end
        bus.i_btn[1] = 1'b1;
        clear_counts();
        run(8);
        checks++;
        if (bus.o_led !== 10'd0 || mv_cnt[0] != 0 || bus.o_dir[1:0] !== 2'd2) begin
            failures++; $display("FAIL release: led=%h moves=%0d dir=%0d expected 000 0 2", bus.o_led, mv_cnt[0], bus.o_dir[1:0]);
        end
    endtask

    task automatic test_bounce();
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            bus.i_btn[0] = i[0];
            run(2);
        end
        bus.i_btn[0] = 1'b1;
        run(10);
        checks++;
        if (led_seen !== 10'd0 || mv_cnt[0] != 0) begin
            failures++; $display("FAIL bounce: led_seen=%h moves=%0d expected 000 0", led_seen, mv_cnt[0]);
        end
    endtask

    task automatic test_priority();
        clear_counts();
        bus.i_btn[0] = 1'b0; bus.i_btn[2] = 1'b0;
        run(8);
        checks++;
        if (bus.o_dir[1:0] !== 2'd0 || mv_cnt[0] != 1) begin
            failures++; $display("FAIL up_left: dir=%0d moves=%0d expected 0 1", bus.o_dir[1:0], mv_cnt[0]);
        end
        clear_counts();
        bus.i_btn[0] = 1'b1;
        run(8);
        checks++;
        if (bus.o_dir[1:0] !== 2'd3 || mv_cnt[0] != 0) begin
            failures++; $display("FAIL up_release: dir=%0d moves=%0d expected 3 0", bus.o_dir[1:0], mv_cnt[0]);
        end
        bus.i_btn[2] = 1'b1;
        run(8);
        checks++;
        if (bus.o_dir[1:0] !== 2'd3 || mv_cnt[0] != 0) begin
            failures++; $display("FAIL dir_hold: dir=%0d moves=%0d expected 3 0", bus.o_dir[1:0], mv_cnt[0]);
        end
    endtask

    task automatic test_fire();
        bus.i_btn[4] = 1'b0;
        run(8);
        checks++;
        if (bus.o_fire_req !== 2'b01) begin
            failures++; $display("FAIL fire_set: req=%b expected 01", bus.o_fire_req);
        end
        bus.i_btn[4] = 1'b1; run(8);
        bus.i_btn[4] = 1'b0; run(8);
        checks++;
        if (bus.o_fire_req !== 2'b01) begin
            failures++; $display("FAIL fire_dropped: req=%b expected 01", bus.o_fire_req);
        end
        bus.i_fire_ack[0] = 1'b1;
        tick();
        bus.i_fire_ack[0] = 1'b0;
        checks++;
        if (bus.o_fire_req !== 2'b00) begin
            failures++; $display("FAIL fire_ack: req=%b expected 00", bus.o_fire_req);
        end
        bus.i_fire_ack[0] = 1'b1;
        tick();
        bus.i_fire_ack[0] = 1'b0;
        checks++;
        if (bus.o_fire_req !== 2'b00) begin
            failures++; $display("FAIL ack_idle: req=%b expected 00", bus.o_fire_req);
        end
        bus.i_btn[4] = 1'b1; run(8);
        bus.i_btn[4] = 1'b0; run(8);
        bus.i_btn[4] = 1'b1; run(8);
        checks++;
        if (bus.o_fire_req !== 2'b01) begin
            failures++; $display("FAIL refire: req=%b expected 01", bus.o_fire_req);
        end
        // Press edge lands on edge 7 after the pin falls; ack on that same edge.
        bus.i_btn[4] = 1'b0;
        run(6);
        bus.i_fire_ack[0] = 1'b1;
        tick();
        bus.i_fire_ack[0] = 1'b0;
        run(1);
        checks++;
        if (bus.o_fire_req !== 2'b01) begin
            failures++; $display("FAIL fire_coincident: req=%b expected 01", bus.o_fire_req);
        end
        bus.i_btn[4] = 1'b1;
        run(8);
    endtask

    task automatic test_disable();
        checks++;
        if (bus.o_fire_req !== 2'b01) begin
            failures++; $display("FAIL pending_before_disable: req=%b expected 01", bus.o_fire_req);
        end
        bus.i_enable = 1'b0;
        tick();
        checks++;
        if (bus.o_fire_req !== 2'b00) begin
            failures++; $display("FAIL disable_clears_req: req=%b expected 00", bus.o_fire_req);
        end
        clear_counts();
        bus.i_btn[1] = 1'b0;
        run(8);
        checks++;
        if (mv_cnt[0] != 0 || bus.o_dir[1:0] !== 2'd3 || bus.o_led !== 10'h002) begin
            failures++; $display("FAIL disabled_press: moves=%0d dir=%0d led=%h expected 0 3 002", mv_cnt[0], bus.o_dir[1:0], bus.o_led);
        end
        bus.i_enable = 1'b1;
        run(4);
        checks++;
        if (mv_cnt[0] != 0) begin
            failures++; $display("FAIL no_replay: moves=%0d expected 0", mv_cnt[0]);
        end
        bus.i_btn[1] = 1'b1;
        run(8);
    endtask

    task automatic test_repeat_and_async_reset();
        int bad;
        bad = 0;
        bus.i_btn[3] = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            logic exp_move;
            tick();
`ifdef INPUT_REPEAT_EN
            exp_move = (k == 7) || (k >= 17 && (k - 17) % 3 == 0);
`else
            exp_move = (k == 7);
`endif
            if (bus.o_move[0] !== exp_move) begin
                bad++;
                $display("FAIL move_pattern: cycle %0d move=%b expected %b", k, bus.o_move[0], exp_move);
            end
        end
        checks++;
        if (bad != 0) failures++;
        checks++;
        if (bus.o_dir[1:0] !== 2'd1 || bus.o_led !== 10'h008) begin
            failures++; $display("FAIL right_held: dir=%0d led=%h expected 1 008", bus.o_dir[1:0], bus.o_led);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_dir, bus.o_move, bus.o_fire_req, bus.o_led} !== 26'd0) begin
            failures++; $display("FAIL async_reset: got %h expected 0", {bus.o_dir, bus.o_move, bus.o_fire_req, bus.o_led});
        end
        bus.i_btn = '1;
        #10 rst_n = 1'b1;
        run(10);
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_press_latency();
        test_bounce();
        test_priority();
        test_fire();
        test_disable();
        test_repeat_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
